// File: rtl/eye_tracker_top.sv
// eye_tracker_top
// Top level of the EyeTracker FPGA. A stereo monochrome camera stream is
// captured into ping-pong line buffers, the most recently completed camera
// line is shown side by side (left eye, then right eye) on a 640x480 VGA
// output with an optional dark-pixel (pupil) highlight, and a frame counter
// byte is sent over the UART once per camera frame.
//
// Ports
//   CLK             50 MHz system clock, single clock domain
//   RST             synchronous active-high reset
//   UART_RXD        unused
//   UART_TXD        UART 8N1 transmit, idle high
//   JP[7:0]         JP[7]=1 disables the overlay, JP[6:0] sets the threshold
//   DUMMY0, DUMMY1  unused
//   FVAL/LVAL/DVAL  camera frame / line / data valid
//   DATA_L, DATA_R  left / right camera pixel
//   VGA_CLK         pixel clock, CLK/2
//   VGA_HSYNC/VSYNC active-low syncs
//   VGA_R/G/B       colour channels
module eye_tracker_top #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int PIX_HACT    = 640,
    parameter int BAUD_DIV    = 434
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   UART_RXD,
    output logic                   UART_TXD,
    input  logic [7:0]             JP,
    input  logic                   DUMMY0,
    input  logic                   DUMMY1,
    input  logic                   FVAL,
    input  logic                   LVAL,
    input  logic                   DVAL,
    input  logic [PIXEL_WIDTH-1:0] DATA_L,
    input  logic [PIXEL_WIDTH-1:0] DATA_R,
    output logic                   VGA_CLK,
    output logic                   VGA_HSYNC,
    output logic                   VGA_VSYNC,
    output logic [PIXEL_WIDTH-1:0] VGA_R,
    output logic [PIXEL_WIDTH-1:0] VGA_G,
    output logic [PIXEL_WIDTH-1:0] VGA_B
);

    localparam int HALF         = PIX_HACT / 2;
    localparam int DEPTH        = 1 << ADDR_WIDTH;
    localparam int WR_LIMIT     = (HALF < DEPTH) ? HALF : DEPTH;
    localparam int XW           = 16;
    localparam int H_TOTAL      = PIX_HACT + 16 + 96 + 48;
    localparam int H_SYNC_START = PIX_HACT + 16;
    localparam int H_SYNC_END   = PIX_HACT + 16 + 96 - 1;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;
    localparam int V_TOTAL      = 525;
    localparam int BW           = $clog2(BAUD_DIV);

    logic unused_inputs;
    assign unused_inputs = ^{UART_RXD, DUMMY0, DUMMY1};

    // ------------------------------------------------------------------
    // Camera input registers and edge detection
    // ------------------------------------------------------------------
    logic                   fval_q, lval_q, dval_q, fval_d, lval_d;
    logic [PIXEL_WIDTH-1:0] data_l_q, data_r_q;
    logic                   lval_rise, lval_fall, fval_fall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            dval_q   <= 1'b0;
            fval_d   <= 1'b0;
            lval_d   <= 1'b0;
            data_l_q <= '0;
            data_r_q <= '0;
        end else begin
            fval_q   <= FVAL;
            lval_q   <= LVAL;
            dval_q   <= DVAL;
            fval_d   <= fval_q;
            lval_d   <= lval_q;
            data_l_q <= DATA_L;
            data_r_q <= DATA_R;
        end
    end

    assign lval_rise = lval_q & ~lval_d;
    assign lval_fall = ~lval_q & lval_d;
    assign fval_fall = ~fval_q & fval_d;

    // ------------------------------------------------------------------
    // Line capture. The x counter saturates so that very long lines can
    // never wrap back onto low addresses.
    // ------------------------------------------------------------------
    logic [XW-1:0] x_cnt, x_eff;
    logic          bank;
    logic          wr_en;

    assign x_eff = lval_rise ? '0 : x_cnt;
    assign wr_en = dval_q & fval_q & (x_eff < XW'(WR_LIMIT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_cnt <= '0;
            bank  <= 1'b0;
        end else begin
            if (dval_q && (x_eff != '1))
                x_cnt <= x_eff + XW'(1);
            else
                x_cnt <= x_eff;
            if (lval_fall && fval_q)
                bank <= ~bank;
        end
    end

    // Both banks live in one array per eye; the bank bit is the address MSB.
    logic [PIXEL_WIDTH-1:0] mem_l [0:2*DEPTH-1];
    logic [PIXEL_WIDTH-1:0] mem_r [0:2*DEPTH-1];
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [PIXEL_WIDTH-1:0] rd_l, rd_r;

    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_l[{bank, x_eff[ADDR_WIDTH-1:0]}] <= data_l_q;
            mem_r[{bank, x_eff[ADDR_WIDTH-1:0]}] <= data_r_q;
        end
        rd_l <= mem_l[{~bank, rd_addr}];
        rd_r <= mem_r[{~bank, rd_addr}];
    end

    // ------------------------------------------------------------------
    // VGA timing: counters step when the pixel clock rises.
    // ------------------------------------------------------------------
    logic       vga_clk;
    logic [9:0] h_cnt, v_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vga_clk <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            vga_clk <= ~vga_clk;
            if (!vga_clk) begin
                if (h_cnt == 10'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    assign VGA_CLK = vga_clk;

    logic       rd_side, active, hsync_n, vsync_n;
    logic [9:0] h_off;

    always_comb begin
        rd_side = (h_cnt >= 10'(HALF));
        h_off   = rd_side ? (h_cnt - 10'(HALF)) : h_cnt;
        rd_addr = ADDR_WIDTH'(h_off);
        active  = (h_cnt < 10'(PIX_HACT)) && (v_cnt < 10'(V_ACTIVE));
        hsync_n = !((h_cnt >= 10'(H_SYNC_START)) && (h_cnt <= 10'(H_SYNC_END)));
        vsync_n = !((v_cnt >= 10'(V_SYNC_START)) && (v_cnt <= 10'(V_SYNC_END)));
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: four CLK stages so syncs and colour stay aligned.
    // Stage 1 is the buffer read, stage 2 picks the eye, stage 3 applies
    // the overlay, stage 4 is the output register.
    // ------------------------------------------------------------------
    logic                   act1, side1, hs1, vs1;
    logic                   act2, hs2, vs2;
    logic                   hs3, vs3;
    logic [PIXEL_WIDTH-1:0] pix2;
    logic [PIXEL_WIDTH-1:0] red3, grn3, blu3;
    logic [PIXEL_WIDTH-1:0] red_c, grn_c, blu_c;
    logic [7:0]             threshold;

    assign threshold = {JP[6:0], 1'b0};

    always_comb begin
        red_c = '0;
        grn_c = '0;
        blu_c = '0;
        if (act2) begin
            if (!JP[7] && (pix2 < PIXEL_WIDTH'(threshold))) begin
                red_c = '1;
            end else begin
                red_c = pix2;
                grn_c = pix2;
                blu_c = pix2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            act1      <= 1'b0;
            side1     <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            act2      <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            pix2      <= '0;
            hs3       <= 1'b1;
            vs3       <= 1'b1;
            red3      <= '0;
            grn3      <= '0;
            blu3      <= '0;
            VGA_HSYNC <= 1'b1;
            VGA_VSYNC <= 1'b1;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else begin
            act1      <= active;
            side1     <= rd_side;
            hs1       <= hsync_n;
            vs1       <= vsync_n;
            act2      <= act1;
            hs2       <= hs1;
            vs2       <= vs1;
            pix2      <= side1 ? rd_r : rd_l;
            hs3       <= hs2;
            vs3       <= vs2;
            red3      <= red_c;
            grn3      <= grn_c;
            blu3      <= blu_c;
            VGA_HSYNC <= hs3;
            VGA_VSYNC <= vs3;
            VGA_R     <= red3;
            VGA_G     <= grn3;
            VGA_B     <= blu3;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter. A frame end is only accepted while idle, but the
    // frame counter advances on every frame end regardless.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t      tx_state, tx_next;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     tx_shift;
    logic [7:0]     frame_cnt;
    logic           bit_done;

    assign bit_done = (baud_cnt == BW'(BAUD_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (fval_fall) tx_next = TX_START;
            TX_START: if (bit_done) tx_next = TX_DATA;
            TX_DATA:  if (bit_done && (bit_idx == 3'd7)) tx_next = TX_STOP;
            TX_STOP:  if (bit_done) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        UART_TXD = 1'b1;
        case (tx_state)
            TX_START: UART_TXD = 1'b0;
            TX_DATA:  UART_TXD = tx_shift[0];
            default:  UART_TXD = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_shift  <= '0;
        end else begin
            if (fval_fall)
                frame_cnt <= frame_cnt + 8'd1;
            if (tx_state == TX_IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (fval_fall)
                    tx_shift <= frame_cnt;
            end else begin
                baud_cnt <= bit_done ? '0 : baud_cnt + BW'(1);
                if (bit_done && (tx_state == TX_DATA)) begin
                    tx_shift <= tx_shift >> 1;
                    bit_idx  <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eye_tracker_top.sv
// tb_eye_tracker_top
// Directed self-checking bench for eye_tracker_top. A cycle counter started
// at reset release gives the expected VGA counter position; a two-bank line
// model gives the expected pixels; UART bytes are sampled near both ends of
// every bit cell.
module tb_eye_tracker_top;

    localparam int BAUD = 434;
    localparam int HALF = 320;

    logic       CLK = 1'b0;
    logic       RST;
    logic       UART_RXD;
    logic       UART_TXD;
    logic [7:0] JP;
    logic       DUMMY0, DUMMY1;
    logic       FVAL, LVAL, DVAL;
    logic [7:0] DATA_L, DATA_R;
    logic       VGA_CLK, VGA_HSYNC, VGA_VSYNC;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    eye_tracker_top #(
        .PIXEL_WIDTH(8),
        .ADDR_WIDTH (9),
        .PIX_HACT   (640),
        .BAUD_DIV   (BAUD)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .UART_RXD (UART_RXD),
        .UART_TXD (UART_TXD),
        .JP       (JP),
        .DUMMY0   (DUMMY0),
        .DUMMY1   (DUMMY1),
        .FVAL     (FVAL),
        .LVAL     (LVAL),
        .DVAL     (DVAL),
        .DATA_L   (DATA_L),
        .DATA_R   (DATA_R),
        .VGA_CLK  (VGA_CLK),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .VGA_R    (VGA_R),
        .VGA_G    (VGA_G),
        .VGA_B    (VGA_B)
    );

    always #10 CLK = ~CLK;

    // Number of rising edges since reset was released.
    int cyc;
    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mdl_l  [0:1][0:HALF-1];
    logic [7:0] mdl_r  [0:1][0:HALF-1];
    bit         mdl_ok [0:1][0:HALF-1];
    int         wbank;
    int         frame_model;

    function automatic logic [7:0] pix(input int mode, input int x, input bit right);
        int val;
        case (mode)
            0:       val = right ? x : x + 16;
            1:       val = right ? x * 5 + 1 : x * 3 + 5;
            2:       val = right ? 8'h11 : 8'hEE;
            3:       val = right ? x + 100 : 255 - x;
            4:       val = right ? 255 - x : x;
            default: val = right ? x * 13 + (x >> 4) + 3 : x * 7 + (x >> 5);
        endcase
        return val[7:0];
    endfunction

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < HALF; c++)
                mdl_ok[b][c] = 1'b0;
        wbank       = 0;
        frame_model = 0;
    endtask

    // Compare syncs, pixel clock and colour against the timing model for n cycles.
    task automatic check_vga(input int n, input string tag);
        logic [26:0] obs, expv, mask;
        int p, h, v, c, rb;
        bit hs, vs, act;
        logic [7:0] px;
        logic [23:0] rgb;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            mask = '1;
            rgb  = 24'h0;
            hs   = 1'b1;
            vs   = 1'b1;
            if (cyc >= 4) begin
                p   = (cyc - 3) / 2;
                h   = p % 800;
                v   = (p / 800) % 525;
                hs  = !(h >= 656 && h <= 751);
                vs  = !(v >= 490 && v <= 491);
                act = (h < 640) && (v < 480);
                if (act) begin
                    rb = wbank ^ 1;
                    c  = (h < HALF) ? h : h - HALF;
                    if (!mdl_ok[rb][c]) begin
                        mask[23:0] = 24'h0;
                    end else begin
                        px = (h < HALF) ? mdl_l[rb][c] : mdl_r[rb][c];
                        if (!JP[7] && (px < {JP[6:0], 1'b0}))
                            rgb = {8'hFF, 8'h00, 8'h00};
                        else
                            rgb = {px, px, px};
                    end
                end
            end
            expv = {hs, vs, 1'(cyc % 2), rgb};
            obs  = {VGA_HSYNC, VGA_VSYNC, VGA_CLK, VGA_R, VGA_G, VGA_B};
            vectors++;
            if ((obs & mask) !== (expv & mask)) begin
                miscompares++;
                $display("[TB] FAIL %s cyc=%0d {hs,vs,clk,rgb} got=%h exp=%h mask=%h",
                         tag, cyc, obs, expv, mask);
            end
        end
    endtask

    task automatic fval_pulse();
        @(negedge CLK);
        FVAL = 1'b1;
        repeat (4) @(negedge CLK);
        FVAL = 1'b0;
    endtask

    // Wait for a start bit, then sample each of the 10 bit cells 2 cycles
    // after it begins and 3 cycles before it ends. If drop_off > 0 another
    // frame end is generated that many cycles into the byte.
    task automatic recv_byte(input logic [7:0] expb, input string tag, input int drop_off);
        bit found;
        logic [9:0] early, late, expf;
        found = 1'b0;
        early = '0;
        late  = '0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge CLK);
            if (UART_TXD === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL %s start bit timeout got TXD=%b exp 0", tag, UART_TXD);
            return;
        end
        for (int off = 0; off < 10 * BAUD; off++) begin
            if (off > 0) @(negedge CLK);
            if (drop_off > 0 && off == drop_off - 5) FVAL = 1'b1;
            if (drop_off > 0 && off == drop_off)     FVAL = 1'b0;
            if (off % BAUD == 2)        early[off / BAUD] = UART_TXD;
            if (off % BAUD == BAUD - 3) late[off / BAUD]  = UART_TXD;
        end
        expf = {1'b1, expb, 1'b0};
        vectors++;
        if (early !== expf) begin
            miscompares++;
            $display("[TB] FAIL %s early bit samples got=%b exp=%b", tag, early, expf);
        end
        vectors++;
        if (late !== expf) begin
            miscompares++;
            $display("[TB] FAIL %s late bit samples got=%b exp=%b", tag, late, expf);
        end
    endtask

    // One camera line; the model mirrors what should land in the write bank.
    task automatic send_line(input int npix, input int mode, input bit fv, input int gap_at);
        @(negedge CLK);
        FVAL = fv;
        LVAL = 1'b1;
        DVAL = 1'b0;
        @(negedge CLK);
        for (int x = 0; x < npix; x++) begin
            @(negedge CLK);
            if (x == gap_at) begin
                DVAL = 1'b0;
                @(negedge CLK);
            end
            DVAL   = 1'b1;
            DATA_L = pix(mode, x, 1'b0);
            DATA_R = pix(mode, x, 1'b1);
            if (fv && x < HALF) begin
                mdl_l[wbank][x]  = DATA_L;
                mdl_r[wbank][x]  = DATA_R;
                mdl_ok[wbank][x] = 1'b1;
            end
        end
        @(negedge CLK);
        DVAL   = 1'b0;
        DATA_L = 8'h00;
        DATA_R = 8'h00;
        repeat (2) @(negedge CLK);
        LVAL = 1'b0;
        if (fv) wbank = wbank ^ 1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        obs = {VGA_HSYNC, VGA_VSYNC, UART_TXD, VGA_CLK, VGA_R, VGA_G, VGA_B};
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 24'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 24'h0});
        end
        clear_model();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            vectors++;
            if (VGA_CLK !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL vga_clk_toggle i=%0d got=%b exp=%b", i, VGA_CLK, (i % 2 == 0));
            end
        end
    endtask

    task automatic test_vga_timing();
        check_vga(3 * 1600 + 100, "vga_timing");
    endtask

    task automatic test_uart();
        for (int i = 0; i < 3; i++) begin
            fval_pulse();
            recv_byte(frame_model[7:0], "uart_byte", 0);
            frame_model++;
            repeat (100) @(negedge CLK);
        end
    endtask

    task automatic test_uart_drop();
        int lows;
        fval_pulse();
        recv_byte(frame_model[7:0], "uart_drop_first", 100);
        frame_model += 2;
        lows = 0;
        repeat (600) begin
            @(negedge CLK);
            if (UART_TXD !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0) begin
            miscompares++;
            $display("[TB] FAIL uart_drop_idle low_cycles got=%0d exp=0", lows);
        end
        fval_pulse();
        recv_byte(frame_model[7:0], "uart_drop_next", 0);
        frame_model++;
        repeat (50) @(negedge CLK);
    endtask

    task automatic test_reset_midstream();
        logic [28:0] obs;
        bit found;
        fval_pulse();
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge CLK);
            if (UART_TXD === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL midreset_start timeout got TXD=%b exp 0", UART_TXD);
        end
        repeat (1000) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        obs = {VGA_HSYNC, VGA_VSYNC, UART_TXD, VGA_CLK, VGA_R, VGA_G, VGA_B};
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 24'h0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_values got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 24'h0});
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        clear_model();
        repeat (5) @(negedge CLK);
        fval_pulse();
        recv_byte(frame_model[7:0], "midreset_counter", 0);
        frame_model++;
        repeat (50) @(negedge CLK);
    endtask

    task automatic test_capture();
        JP = 8'h80;
        send_line(360, 0, 1'b1, -1);
        check_vga(1700, "capture_line_a");
        send_line(330, 1, 1'b1, 100);
        check_vga(1700, "capture_line_b");
        send_line(330, 2, 1'b0, -1);
        check_vga(1700, "capture_fval_low");
        send_line(10, 3, 1'b1, -1);
        check_vga(1700, "capture_partial");
    endtask

    task automatic test_overlay();
        logic [7:0] jps [0:3];
        jps[0] = 8'h7F;
        jps[1] = 8'h00;
        jps[2] = 8'h05;
        jps[3] = 8'h85;
        send_line(HALF, 4, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            JP = jps[i];
            repeat (8) @(negedge CLK);
            check_vga(1700, $sformatf("overlay_jp%02h", jps[i]));
        end
        JP = 8'h80;
    endtask

    task automatic test_overflow();
        send_line(700, 5, 1'b1, -1);
        check_vga(1700, "overflow_700");
    endtask

    initial begin
        RST      = 1'b1;
        UART_RXD = 1'b1;
        JP       = 8'h80;
        DUMMY0   = 1'b0;
        DUMMY1   = 1'b0;
        FVAL     = 1'b0;
        LVAL     = 1'b0;
        DVAL     = 1'b0;
        DATA_L   = 8'h00;
        DATA_R   = 8'h00;
        test_reset();
        test_vga_timing();
        test_uart();
        test_uart_drop();
        test_reset_midstream();
        test_capture();
        test_overlay();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/eye_tracker_top.md
Name: eye_tracker_top

Overview:
- Top level of the EyeTracker FPGA.
- Captures a stereo monochrome camera stream (left/right 8-bit pixels with FVAL/LVAL/DVAL framing) into ping-pong line buffers.
- Re-displays the latest completed camera line side by side on a 640x480 VGA output, with a jumper-controlled dark-pixel (pupil) highlight.
- Reports a frame counter over a UART transmitter once per camera frame.

Parameters:
- PIXEL_WIDTH, 8, bit width of camera pixels and of each VGA colour channel.
- ADDR_WIDTH, 9, address width of each line buffer (2^ADDR_WIDTH entries per eye per bank).
- PIX_HACT, 640, VGA active width; left eye occupies columns 0..PIX_HACT/2-1, right eye occupies the rest.
- BAUD_DIV, 434, CLK cycles per UART bit (50 MHz / 115200).

Ports:
- CLK  in  1  system clock, 50 MHz; the single clock domain, every register on its rising edge.
- RST  in  1  synchronous active-high reset.
- UART_RXD  in  1  unused, ignored.
- UART_TXD  out  1  UART 8N1 transmit, idle high.
- JP  in  8  jumpers: JP[7]=1 disables overlay; JP[6:0] sets threshold.
- DUMMY0, DUMMY1  in  1  unused, ignored.
- FVAL, LVAL, DVAL  in  1  camera frame/line/data valid, synchronous to CLK.
- DATA_L, DATA_R  in  PIXEL_WIDTH  left/right camera pixel, valid when DVAL=1.
- VGA_CLK  out  1  VGA pixel clock, CLK/2.
- VGA_HSYNC, VGA_VSYNC  out  1  sync, active low.
- VGA_R, VGA_G, VGA_B  out  PIXEL_WIDTH  colour.

Behaviour:
- Reset:
  - VGA_CLK=0; VGA_HSYNC=VGA_VSYNC=1; VGA_R/G/B=0; UART_TXD=1.
  - Both VGA counters, camera x counter, bank select and frame counter cleared.
  - Buffer contents undefined.
  - Reset asserted mid-frame or mid-UART-byte aborts immediately to these values.
- Camera capture:
  - Inputs registered once.
  - x counter clears on LVAL rising edge and increments on every sample with DVAL=1.
  - While DVAL=1 and x < PIX_HACT/2 and x < 2^ADDR_WIDTH, write DATA_L and DATA_R at address x into the write bank; other pixels are dropped.
  - On LVAL falling edge while FVAL=1, the write bank becomes the read bank (bank select toggles).
  - DVAL while FVAL=0 writes nothing.
- VGA timing:
  - VGA_CLK toggles every CLK.
  - h/v counters advance on CLK cycles where VGA_CLK goes 0->1 (every 2 CLK).
  - Horizontal: 800 total (640 active, front porch 16, sync 96, back porch 48); HSYNC low for h in 656..751.
  - Vertical: 525 total (480 active, front porch 10, sync 2, back porch 33); VSYNC low for v in 490..491.
  - h wraps 799->0 and increments v; v wraps 524->0.
- Pixel path:
  - Active region: h<640 and v<480.
  - Read address = h for h<PIX_HACT/2 (DATA_L buffer), h-PIX_HACT/2 otherwise (DATA_R buffer), from the read bank.
  - Pixel p: if JP[7]=0 and p < {JP[6:0],1'b0}, output R=255, G=0, B=0; otherwise R=G=B=p.
  - Outside the active region RGB=0.
  - Sync and RGB outputs are registered with identical pipeline delay: 2 VGA pixels (4 CLK) after counter value.
  - A bank swap during a VGA line takes effect at the next read; no tearing protection required.
- UART:
  - On each FVAL falling edge, latch an 8-bit frame counter, then increment it (wraps 255->0).
  - Transmit: start bit 0, 8 data bits LSB first, stop bit 1; each bit BAUD_DIV CLK cycles.
  - A frame end arriving while a byte is still in flight is dropped, but the counter still increments.

Test Plan:
- Reset: hold RST 10 cycles -> VGA_HSYNC=VGA_VSYNC=UART_TXD=1, RGB=0, VGA_CLK=0; after release VGA_CLK toggles every CLK.
- VGA timing: run 2 frames -> HSYNC low 192 CLK of every 1600 CLK; VSYNC low 2 lines every 525 lines; RGB=0 outside active area.
- Capture/display: camera frame 360x492 (LVAL from column 39, FVAL from line 11), DATA_R=n&255, DATA_L=(n+16)&255, JP=8'h80 -> active VGA column c<320 shows the left value written at x=c in the last completed line, column 320+c shows the right value at x=c, with R=G=B.
- Overlay: JP=8'h7F (threshold 254), pixel 200 -> RGB=(255,0,0); pixel 254 -> (254,254,254); JP=8'h00 -> no pixel highlighted.
- UART: three FVAL falling edges spaced > 10*BAUD_DIV -> bytes 0x00, 0x01, 0x02 each framed with start 0/stop 1, bit time 434 CLK.
- Overflow/drop: 700 DVAL pixels in one line -> only x<320 stored, no address wrap corruption; two FVAL falls 100 CLK apart -> one byte sent, next byte value skips by 2.
